// File: rtl/abs_angle_arbiter.sv
// Two-channel front end sharing one cal_abs_angle engine: round-robin issue, a tag FIFO
// recording the issuing channel, and per-channel result demux.
module abs_angle_arbiter #(
    parameter int unsigned DW        = 8,
    parameter int unsigned ANG_W     = 16,
    parameter int unsigned TAG_DEPTH = 16,
    parameter int unsigned ENG_LAT   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    ch0_real_i,
    input  logic [DW-1:0]    ch0_imag_i,
    input  logic             ch0_val_i,
    output logic             ch0_rdy_o,
    input  logic [DW-1:0]    ch1_real_i,
    input  logic [DW-1:0]    ch1_imag_i,
    input  logic             ch1_val_i,
    output logic             ch1_rdy_o,
    output logic [DW-1:0]    eng_real_o,
    output logic [DW-1:0]    eng_imag_o,
    output logic             eng_val_o,
    input  logic [DW-1:0]    eng_abs_i,
    input  logic [ANG_W-1:0] eng_angle_i,
    input  logic             eng_val_i,
    output logic [DW-1:0]    ch0_abs_o,
    output logic [ANG_W-1:0] ch0_angle_o,
    output logic             ch0_val_o,
    output logic [DW-1:0]    ch1_abs_o,
    output logic [ANG_W-1:0] ch1_angle_o,
    output logic             ch1_val_o,
    output logic             busy_o,
    output logic             err_o
);
    localparam int unsigned PtrW   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(TAG_DEPTH + 1);
    localparam int unsigned FlushW = $clog2(ENG_LAT + 2);
    localparam logic [FlushW-1:0] FlushLoad = FlushW'(ENG_LAT + 1);
    localparam logic [CntW-1:0]   CntFull   = CntW'(TAG_DEPTH);

    logic [FlushW-1:0]    flush_q, flush_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [TAG_DEPTH-1:0] tag_mem_q;
    logic                 last_grant_q;
    logic                 err_q;
    logic [DW-1:0]        eng_real_q, eng_imag_q;
    logic                 eng_val_q;
    logic [DW-1:0]        ch0_abs_q, ch1_abs_q;
    logic [ANG_W-1:0]     ch0_angle_q, ch1_angle_q;
    logic                 ch0_val_q, ch1_val_q;

    logic flush_active, full, can_issue;
    logic grant0, grant1, push, pop, pop_tag, res_valid, orphan;

    // Arbitration looks only at registered state, so a same-cycle pop never frees a slot.
    always_comb begin
        flush_active = (flush_q != '0);
        full         = (count_q == CntFull);
        can_issue    = !flush_active && !full;
        grant0       = can_issue && ch0_val_i && (!ch1_val_i || last_grant_q);
        grant1       = can_issue && ch1_val_i && (!ch0_val_i || !last_grant_q);
        push         = grant0 || grant1;
        // The engine has no reset, so anything it emits during the flush window is stale.
        res_valid    = eng_val_i && !flush_active;
        pop          = res_valid && (count_q != '0);
        orphan       = res_valid && (count_q == '0);
        pop_tag      = tag_mem_q[rd_ptr_q];
    end

    always_comb begin
        flush_d = flush_q;
        if (flush_active) begin
            flush_d = flush_q - 1'b1;
        end
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q      <= FlushLoad;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_mem_q    <= '0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            eng_real_q   <= '0;
            eng_imag_q   <= '0;
            eng_val_q    <= 1'b0;
            ch0_abs_q    <= '0;
            ch0_angle_q  <= '0;
            ch0_val_q    <= 1'b0;
            ch1_abs_q    <= '0;
            ch1_angle_q  <= '0;
            ch1_val_q    <= 1'b0;
        end else begin
            flush_q   <= flush_d;
            count_q   <= count_d;
            eng_val_q <= push;
            if (push) begin
                eng_real_q          <= grant1 ? ch1_real_i : ch0_real_i;
                eng_imag_q          <= grant1 ? ch1_imag_i : ch0_imag_i;
                tag_mem_q[wr_ptr_q] <= grant1;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
                last_grant_q        <= grant1;
            end
            ch0_val_q <= pop && !pop_tag;
            ch1_val_q <= pop && pop_tag;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                if (pop_tag) begin
                    ch1_abs_q   <= eng_abs_i;
                    ch1_angle_q <= eng_angle_i;
                end else begin
                    ch0_abs_q   <= eng_abs_i;
                    ch0_angle_q <= eng_angle_i;
                end
            end
            if (orphan) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ch0_rdy_o   = grant0;
    assign ch1_rdy_o   = grant1;
    assign eng_real_o  = eng_real_q;
    assign eng_imag_o  = eng_imag_q;
    assign eng_val_o   = eng_val_q;
    assign ch0_abs_o   = ch0_abs_q;
    assign ch0_angle_o = ch0_angle_q;
    assign ch0_val_o   = ch0_val_q;
    assign ch1_abs_o   = ch1_abs_q;
    assign ch1_angle_o = ch1_angle_q;
    assign ch1_val_o   = ch1_val_q;
    assign busy_o      = flush_active || (count_q != '0);
    assign err_o       = err_q;

endmodule

// File: tb/tb_abs_angle_arbiter.sv
// Directed bench for abs_angle_arbiter; a behavioural engine returns abs = |z| and
// angle = {real, imag} so every routed result is traceable to its sample.
module tb_abs_angle_arbiter;
    localparam int unsigned DW        = 8;
    localparam int unsigned ANG_W     = 16;
    localparam int unsigned TAG_DEPTH = 4;
    localparam int unsigned ENG_LAT   = 3;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] ch0_real, ch0_imag, ch1_real, ch1_imag;
    logic ch0_val, ch1_val, ch0_rdy, ch1_rdy;
    logic [DW-1:0] eng_real_o, eng_imag_o;
    logic eng_val_o;
    logic [DW-1:0] eng_abs_m = '0;
    logic [ANG_W-1:0] eng_ang_m = '0;
    logic eng_val_m = 1'b0;
    logic [DW-1:0] ch0_abs_o, ch1_abs_o;
    logic [ANG_W-1:0] ch0_angle_o, ch1_angle_o;
    logic ch0_val_o, ch1_val_o, busy_o, err_o;

    logic hold = 1'b0;
    logic force_val = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int rx0 = 0;
    int rx1 = 0;

    // Pythagorean vectors: magnitudes are exact, worked out by hand.
    logic [7:0] vre [8];
    logic [7:0] vim [8];
    logic [7:0] vabs [8];

    logic [23:0] exp0 [$];
    logic [23:0] exp1 [$];
    int grant_log [$];

    typedef struct {
        logic [7:0] re;
        logic [7:0] im;
        int unsigned rel;
    } eng_entry_t;
    eng_entry_t eq [$];
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    abs_angle_arbiter #(
        .DW        (DW),
        .ANG_W     (ANG_W),
        .TAG_DEPTH (TAG_DEPTH),
        .ENG_LAT   (ENG_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch0_real_i  (ch0_real),
        .ch0_imag_i  (ch0_imag),
        .ch0_val_i   (ch0_val),
        .ch0_rdy_o   (ch0_rdy),
        .ch1_real_i  (ch1_real),
        .ch1_imag_i  (ch1_imag),
        .ch1_val_i   (ch1_val),
        .ch1_rdy_o   (ch1_rdy),
        .eng_real_o  (eng_real_o),
        .eng_imag_o  (eng_imag_o),
        .eng_val_o   (eng_val_o),
        .eng_abs_i   (eng_abs_m),
        .eng_angle_i (eng_ang_m),
        .eng_val_i   (eng_val_m),
        .ch0_abs_o   (ch0_abs_o),
        .ch0_angle_o (ch0_angle_o),
        .ch0_val_o   (ch0_val_o),
        .ch1_abs_o   (ch1_abs_o),
        .ch1_angle_o (ch1_angle_o),
        .ch1_val_o   (ch1_val_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] isqrt(input int unsigned v);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r[7:0];
    endfunction

    // Engine model: fixed latency ENG_LAT, output may be stalled by hold, no reset.
    always @(posedge clk) begin
        eng_val_m <= 1'b0;
        if (force_val) begin
            eng_val_m <= 1'b1;
            eng_abs_m <= 8'h77;
            eng_ang_m <= 16'hbeef;
        end else if (!hold && eq.size() > 0 && cyc >= eq[0].rel) begin
            eng_val_m <= 1'b1;
            eng_abs_m <= isqrt(eq[0].re * eq[0].re + eq[0].im * eq[0].im);
            eng_ang_m <= {eq[0].re, eq[0].im};
            void'(eq.pop_front());
        end
        if (eng_val_o) eq.push_back('{eng_real_o, eng_imag_o, cyc + ENG_LAT - 1});
        cyc <= cyc + 1;
    end

    // Result scoreboard and grant exclusivity.
    always @(negedge clk) begin
        logic [23:0] e;
        if (ch0_val_o) begin
            rx0++;
            check("ch0_pending", 32'(exp0.size() > 0), 32'd1);
            if (exp0.size() > 0) begin
                e = exp0.pop_front();
                check("ch0_abs", 32'(ch0_abs_o), 32'(e[23:16]));
                check("ch0_angle", 32'(ch0_angle_o), 32'(e[15:0]));
            end
        end
        if (ch1_val_o) begin
            rx1++;
            check("ch1_pending", 32'(exp1.size() > 0), 32'd1);
            if (exp1.size() > 0) begin
                e = exp1.pop_front();
                check("ch1_abs", 32'(ch1_abs_o), 32'(e[23:16]));
                check("ch1_angle", 32'(ch1_angle_o), 32'(e[15:0]));
            end
        end
        if (ch0_rdy || ch1_rdy) check("rdy_excl", 32'(ch0_rdy && ch1_rdy), 32'd0);
    end

    // Holds val on the chosen channels through the flush window and counts rdy-low cycles;
    // vals are dropped before the edge that would accept.
    task automatic flush_wait(input bit use0, input bit use1, output int low);
        low = 0;
        ch0_val = use0; ch0_real = vre[0]; ch0_imag = vim[0];
        ch1_val = use1; ch1_real = vre[4]; ch1_imag = vim[4];
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ch0_rdy || ch1_rdy) break;
            low++;
            @(negedge clk);
        end
        ch0_val = 1'b0;
        ch1_val = 1'b0;
    endtask

    task automatic run_stream(input int n0, input int b0, input int n1, input int b1,
                              input int maxc, output int acc0, output int acc1);
        int p0 = 0;
        int p1 = 0;
        for (int c = 0; c < maxc && (p0 < n0 || p1 < n1); c++) begin
            @(negedge clk);
            ch0_val = (p0 < n0);
            ch1_val = (p1 < n1);
            if (p0 < n0) begin ch0_real = vre[b0 + p0]; ch0_imag = vim[b0 + p0]; end
            if (p1 < n1) begin ch1_real = vre[b1 + p1]; ch1_imag = vim[b1 + p1]; end
            #1;
            if (ch0_val && ch0_rdy) begin
                exp0.push_back({vabs[b0 + p0], vre[b0 + p0], vim[b0 + p0]});
                grant_log.push_back(0);
                p0++;
            end
            if (ch1_val && ch1_rdy) begin
                exp1.push_back({vabs[b1 + p1], vre[b1 + p1], vim[b1 + p1]});
                grant_log.push_back(1);
                p1++;
            end
        end
        acc0 = p0;
        acc1 = p1;
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        ch0_val = 1'b0;
        ch1_val = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 300; c++) begin
            if (exp0.size() == 0 && exp1.size() == 0 && !busy_o) break;
            @(negedge clk);
        end
        check({tag, "_left"}, 32'(exp0.size() + exp1.size()), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int low, a0, a1, r0, r1;
        vre[0] = 3;  vim[0] = 4;  vabs[0] = 5;
        vre[1] = 6;  vim[1] = 8;  vabs[1] = 10;
        vre[2] = 5;  vim[2] = 12; vabs[2] = 13;
        vre[3] = 8;  vim[3] = 15; vabs[3] = 17;
        vre[4] = 9;  vim[4] = 12; vabs[4] = 15;
        vre[5] = 12; vim[5] = 16; vabs[5] = 20;
        vre[6] = 7;  vim[6] = 24; vabs[6] = 25;
        vre[7] = 20; vim[7] = 21; vabs[7] = 29;
        rst = 1'b1;
        ch0_val = 1'b0; ch1_val = 1'b0;
        ch0_real = '0; ch0_imag = '0; ch1_real = '0; ch1_imag = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_eng_val", 32'(eng_val_o), 32'd0);
        check("rst_ch0_val", 32'(ch0_val_o), 32'd0);
        check("rst_ch1_val", 32'(ch1_val_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_abs", 32'(ch0_abs_o), 32'd0);
        rst = 1'b0;
        flush_wait(1'b1, 1'b0, low);
        check("flush_len", 32'(low), 32'(ENG_LAT + 1));

        // Single ch0 sample (3,4): issue latency and result latency
        @(negedge clk);
        ch0_val = 1'b1; ch0_real = 8'h03; ch0_imag = 8'h04;
        #1;
        check("t1_rdy", 32'(ch0_rdy), 32'd1);
        exp0.push_back({8'h05, 8'h03, 8'h04});
        @(negedge clk);
        ch0_val = 1'b0;
        check("t1_eng_val", 32'(eng_val_o), 32'd1);
        check("t1_eng_data", 32'({eng_real_o, eng_imag_o}), 32'h0304);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check("t1_early", 32'(ch0_val_o), 32'd0);
        end
        check("t1_busy_in", 32'(busy_o), 32'd1);
        @(negedge clk);
        check("t1_pulse", 32'(ch0_val_o), 32'd1);
        @(negedge clk);
        check("t1_pulse_end", 32'(ch0_val_o), 32'd0);
        check("t1_busy_out", 32'(busy_o), 32'd0);
        check("t1_ch1_rx", 32'(rx1), 32'd0);

        // Engine stalled: FIFO fills at TAG_DEPTH, then recovers without loss
        @(negedge clk);
        hold = 1'b1;
        r0 = rx0;
        run_stream(6, 0, 0, 0, 12, a0, a1);
        check("hold_acc", 32'(a0), 32'(TAG_DEPTH));
        check("hold_rdy", 32'(ch0_rdy), 32'd0);
        idle_inputs();
        hold = 1'b0;
        run_stream(2, 4, 0, 0, 60, a0, a1);
        check("hold_rest", 32'(a0), 32'd2);
        idle_inputs();
        drain("hold");
        check("hold_rx", 32'(rx0 - r0), 32'd6);

        // Reset with 3 samples in flight: stale results must be discarded
        run_stream(3, 0, 0, 0, 10, a0, a1);
        check("rst3_acc", 32'(a0), 32'd3);
        exp0.delete();
        @(negedge clk);
        ch0_val = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst3_eng_val", 32'(eng_val_o), 32'd0);
        r0 = rx0;
        r1 = rx1;
        flush_wait(1'b1, 1'b1, low);
        check("rst3_flush", 32'(low), 32'(ENG_LAT + 1));
        check("rst3_err", 32'(err_o), 32'd0);

        // Both channels streaming: grants alternate starting with ch0
        grant_log.delete();
        run_stream(4, 0, 4, 4, 60, a0, a1);
        idle_inputs();
        check("rr_acc0", 32'(a0), 32'd4);
        check("rr_acc1", 32'(a1), 32'd4);
        check("rr_glen", 32'(grant_log.size()), 32'd8);
        foreach (grant_log[i]) check("rr_grant", 32'(grant_log[i]), 32'(i % 2));
        drain("rr");
        check("rr_rx0", 32'(rx0 - r0), 32'd4);
        check("rr_rx1", 32'(rx1 - r1), 32'd4);
        check("rr_err", 32'(err_o), 32'd0);

        // Orphan result with an empty FIFO sets the sticky error
        r0 = rx0;
        r1 = rx1;
        @(negedge clk);
        check("orph_pre_err", 32'(err_o), 32'd0);
        force_val = 1'b1;
        @(negedge clk);
        force_val = 1'b0;
        @(negedge clk);
        check("orph_err", 32'(err_o), 32'd1);
        repeat (3) @(negedge clk);
        check("orph_sticky", 32'(err_o), 32'd1);
        check("orph_no_pulse", 32'((rx0 - r0) + (rx1 - r1)), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
